// File: rtl/cps2_video_gen.sv
// Synthetic CPS2-format video source: sync/DE timing from parameters plus per-frame test patterns.
// Optional feature macro VGEN_SCROLL_EN: checkerboard and grid scroll horizontally one pixel per frame.
module cps2_video_gen #(
    parameter int H_TOTAL     = 512,
    parameter int H_SYNCLEN   = 36,
    parameter int H_BACKPORCH = 60,
    parameter int H_ACTIVE    = 384,
    parameter int V_TOTAL     = 262,
    parameter int V_SYNCLEN   = 3,
    parameter int V_BACKPORCH = 28,
    parameter int V_ACTIVE    = 224
) (
    input  logic        PCLK_in,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [15:0] solid_color,
    output logic [3:0]  R_out,
    output logic [3:0]  G_out,
    output logic [3:0]  B_out,
    output logic [3:0]  F_out,
    output logic        HSYNC_out,
    output logic        VSYNC_out,
    output logic        DE_out,
    output logic        frame_start,
    output logic        busy
);
    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_SYNC   = 11'(H_SYNCLEN);
    localparam logic [10:0] V_SYNC   = 11'(V_SYNCLEN);
    localparam logic [10:0] H_START  = 11'(H_SYNCLEN + H_BACKPORCH);
    localparam logic [10:0] H_END    = 11'(H_SYNCLEN + H_BACKPORCH + H_ACTIVE);
    localparam logic [10:0] V_START  = 11'(V_SYNCLEN + V_BACKPORCH);
    localparam logic [10:0] V_END    = 11'(V_SYNCLEN + V_BACKPORCH + V_ACTIVE);
    localparam logic [8:0]  X_LAST   = 9'(H_ACTIVE - 1);
    localparam logic [8:0]  Y_LAST   = 9'(V_ACTIVE - 1);
    localparam logic [8:0]  BAR_LAST = 9'(H_ACTIVE / 8 - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t      state, state_nx;
    logic [10:0] hcnt, vcnt;
    logic [1:0]  pat_q;
    logic [15:0] solid_q;
    logic [8:0]  bar_px;
    logic [2:0]  bar_idx;
    logic [8:0]  x, y;
    logic [4:0]  xp;
    logic [15:0] pix;
    logic        active, origin, at_end, de_now;

    assign active = (state != IDLE);
    assign origin = (hcnt == 11'd0) && (vcnt == 11'd0);
    assign at_end = (hcnt == H_LAST) && (vcnt == V_LAST);
    assign de_now = (hcnt >= H_START) && (hcnt < H_END) && (vcnt >= V_START) && (vcnt < V_END);
    // Modulo-512 subtraction on the low bits gives the 9-bit active coordinates directly.
    assign x = hcnt[8:0] - H_START[8:0];
    assign y = vcnt[8:0] - V_START[8:0];

`ifdef VGEN_SCROLL_EN
    logic [8:0] scroll;

    // Advancing at the frame wrap makes frame n (counted from leaving IDLE) use scroll = n.
    always_ff @(posedge PCLK_in) begin
        if (!reset_n || !active)
            scroll <= 9'd0;
        else if (at_end)
            scroll <= scroll + 9'd1;
    end

    assign xp = 5'(x + scroll);
`else
    assign xp = x[4:0];
`endif

    always_ff @(posedge PCLK_in) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (enable) state_nx = RUN;
            // Dropping enable on the last pixel of a frame has nothing left to drain.
            RUN:     if (!enable) state_nx = at_end ? IDLE : DRAIN;
            DRAIN:   if (at_end) state_nx = enable ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge PCLK_in) begin
        if (!reset_n || !active) begin
            hcnt <= 11'd0;
            vcnt <= 11'd0;
        end else if (hcnt == H_LAST) begin
            hcnt <= 11'd0;
            vcnt <= (vcnt == V_LAST) ? 11'd0 : vcnt + 11'd1;
        end else begin
            hcnt <= hcnt + 11'd1;
        end
    end

    // Bar position is tracked incrementally so no divider is needed; it rezeroes in blanking.
    always_ff @(posedge PCLK_in) begin
        if (!reset_n) begin
            pat_q   <= 2'd0;
            solid_q <= 16'h0;
            bar_px  <= 9'd0;
            bar_idx <= 3'd0;
        end else begin
            if (active && origin) begin
                pat_q   <= pattern_sel;
                solid_q <= solid_color;
            end
            if (active && de_now) begin
                if (bar_px == BAR_LAST) begin
                    bar_px  <= 9'd0;
                    bar_idx <= bar_idx + 3'd1;
                end else begin
                    bar_px <= bar_px + 9'd1;
                end
            end else begin
                bar_px  <= 9'd0;
                bar_idx <= 3'd0;
            end
        end
    end

    // Bar order white,yellow,cyan,green,magenta,red,blue,black maps to R=~i[1], G=~i[2], B=~i[0].
    always_comb begin
        pix = 16'h0;
        if (de_now) begin
            case (pat_q)
                2'd0:    pix = {{4{~bar_idx[1]}}, {4{~bar_idx[2]}}, {4{~bar_idx[0]}}, 4'hF};
                2'd1:    pix = (xp[3] ^ y[3]) ? 16'hFFFF : 16'h000F;
                2'd2:    pix = ((xp == 5'd0) || (y[4:0] == 5'd0) || (x == X_LAST) || (y == Y_LAST))
                               ? 16'hFFFF : 16'h0000;
                default: pix = solid_q;
            endcase
        end
    end

    always_ff @(posedge PCLK_in) begin
        if (!reset_n || !active) begin
            HSYNC_out   <= 1'b1;
            VSYNC_out   <= 1'b1;
            DE_out      <= 1'b0;
            R_out       <= 4'h0;
            G_out       <= 4'h0;
            B_out       <= 4'h0;
            F_out       <= 4'h0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            HSYNC_out   <= (hcnt >= H_SYNC);
            VSYNC_out   <= (vcnt >= V_SYNC);
            DE_out      <= de_now;
            {R_out, G_out, B_out, F_out} <= pix;
            frame_start <= origin;
            busy        <= 1'b1;
        end
    end
endmodule

// File: tb/tb_cps2_video_gen.sv
// Bench for cps2_video_gen: frame-position reference model checked every cycle, plus directed pixel table and sequences.
module tb_cps2_video_gen;
    localparam int HT = 64, HSL = 4, HBP = 8, HA = 40;
    localparam int VT = 40, VSL = 2, VBP = 4, VA = 32;
    localparam int HS = HSL + HBP, VS = VSL + VBP, FT = HT * VT;
`ifdef VGEN_SCROLL_EN
    localparam bit SCROLL = 1'b1;
`else
    localparam bit SCROLL = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n, enable;
    logic [1:0] pattern_sel;
    logic [15:0] solid_color;
    logic [3:0] R_out, G_out, B_out, F_out;
    logic HSYNC_out, VSYNC_out, DE_out, frame_start, busy;

    cps2_video_gen #(
        .H_TOTAL(HT), .H_SYNCLEN(HSL), .H_BACKPORCH(HBP), .H_ACTIVE(HA),
        .V_TOTAL(VT), .V_SYNCLEN(VSL), .V_BACKPORCH(VBP), .V_ACTIVE(VA)
    ) dut (
        .PCLK_in(clk), .reset_n(reset_n), .enable(enable),
        .pattern_sel(pattern_sel), .solid_color(solid_color),
        .R_out(R_out), .G_out(G_out), .B_out(B_out), .F_out(F_out),
        .HSYNC_out(HSYNC_out), .VSYNC_out(VSYNC_out), .DE_out(DE_out),
        .frame_start(frame_start), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // Reference model: mode 0 idle, 1 run, 2 drain; pos is the frame position to emit next.
    int mode = 0, pos = 0, frames = 0, emit_pos = -1, pat_l = 0;
    logic [15:0] sol_l = 16'h0;
    logic e_hs = 1'b1, e_vs = 1'b1, e_de = 1'b0, e_fs = 1'b0, e_busy = 1'b0;
    logic [15:0] e_pix = 16'h0;

    function automatic logic [15:0] ref_pix(int pat, logic [15:0] sol, int x, int y, int sc);
        int bar, xp;
        logic r, g, b;
        xp = (x + sc) % 512;
        case (pat)
            0: begin
                bar = x / (HA / 8);
                r = (bar == 0 || bar == 1 || bar == 4 || bar == 5);
                g = (bar < 4);
                b = (bar % 2 == 0);
                return {r ? 4'hF : 4'h0, g ? 4'hF : 4'h0, b ? 4'hF : 4'h0, 4'hF};
            end
            1: return ((((xp / 8) % 2) ^ ((y / 8) % 2)) != 0) ? 16'hFFFF : 16'h000F;
            2: return (xp % 32 == 0 || y % 32 == 0 || x == HA - 1 || y == VA - 1) ? 16'hFFFF : 16'h0000;
            default: return sol;
        endcase
    endfunction

    task automatic model_edge();
        int h, v;
        bit last;
        if (!reset_n || mode == 0) begin
            {e_hs, e_vs, e_de, e_fs, e_busy, e_pix} = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0};
            emit_pos = -1;
            pos = 0;
            frames = 0;
            if (!reset_n) begin
                mode = 0; pat_l = 0; sol_l = 16'h0;
            end else if (enable) begin
                mode = 1;
            end
        end else begin
            h = pos % HT;
            v = pos / HT;
            if (pos == 0) begin
                pat_l = int'(pattern_sel);
                sol_l = solid_color;
            end
            e_hs = !(h < HSL);
            e_vs = !(v < VSL);
            e_de = (h >= HS && h < HS + HA && v >= VS && v < VS + VA);
            e_fs = (pos == 0);
            e_busy = 1'b1;
            e_pix = e_de ? ref_pix(pat_l, sol_l, h - HS, v - VS, SCROLL ? frames % 512 : 0) : 16'h0;
            emit_pos = pos;
            last = (pos == FT - 1);
            pos = last ? 0 : pos + 1;
            if (last) frames++;
            if (mode == 1 && !enable) mode = last ? 0 : 2;
            else if (mode == 2 && last) mode = enable ? 1 : 0;
        end
    endtask

    task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        cmp($sformatf("stream@%0d", emit_pos),
            {11'd0, HSYNC_out, VSYNC_out, DE_out, frame_start, busy, R_out, G_out, B_out, F_out},
            {11'd0, e_hs, e_vs, e_de, e_fs, e_busy, e_pix});
    endtask

    task automatic run_to(int target);
        int n;
        tick();
        n = 1;
        while (emit_pos != target && n < 2 * FT + 8) begin
            tick();
            n++;
        end
        if (emit_pos != target) begin
            checks++;
            errors++;
            $display("FAIL run_to actual=%0d required=%0d", emit_pos, target);
        end
    endtask

    function automatic int at(int x, int y);
        return (VS + y) * HT + HS + x;
    endfunction

    typedef struct {
        int pat;
        logic [15:0] sol;
        int x;
        int y;
        logic [15:0] exp;
    } vec_t;
    vec_t tbl[11];

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_hs, n_vs, n_de, n_fs, n, trans;
        logic [15:0] prev, cur;

        tbl[0]  = '{0, 16'h0, 0, 0, 16'hFFFF};
        tbl[1]  = '{0, 16'h0, 5, 3, 16'hFF0F};
        tbl[2]  = '{0, 16'h0, 12, 5, 16'h0FFF};
        tbl[3]  = '{0, 16'h0, 27, 31, 16'hF00F};
        tbl[4]  = '{0, 16'h0, 34, 9, 16'h00FF};
        tbl[5]  = '{0, 16'h0, 39, 10, 16'h000F};
        tbl[6]  = '{2, 16'h0, 3, 0, 16'hFFFF};
        tbl[7]  = '{2, 16'h0, 3, 5, 16'h0000};
        tbl[8]  = '{2, 16'h0, 39, 7, 16'hFFFF};
        tbl[9]  = '{2, 16'h0, 7, 31, 16'hFFFF};
        tbl[10] = '{3, 16'hA5C3, 10, 10, 16'hA5C3};

        reset_n = 1'b0;
        enable = 1'b1;
        pattern_sel = 2'd0;
        solid_color = 16'h0;
        repeat (3) tick();
        cmp("reset_outputs", {HSYNC_out, VSYNC_out, DE_out, frame_start, busy, R_out, G_out, B_out, F_out},
            {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0});

        // Startup: first edge enters RUN, second emits the frame origin.
        reset_n = 1'b1;
        tick();
        cmp("start_edge1", {frame_start, busy, HSYNC_out}, 3'b001);
        tick();
        cmp("start_edge2", {frame_start, busy, HSYNC_out, VSYNC_out}, 4'b1100);

        n_hs = !HSYNC_out; n_vs = !VSYNC_out; n_de = DE_out; n_fs = frame_start;
        repeat (FT - 1) begin
            tick();
            n_hs += !HSYNC_out; n_vs += !VSYNC_out; n_de += DE_out; n_fs += frame_start;
        end
        cmp("hsync_low_cycles", n_hs, HSL * VT);
        cmp("vsync_low_cycles", n_vs, VSL * HT);
        cmp("de_cycles", n_de, HA * VA);
        cmp("frame_start_count", n_fs, 1);
        tick();
        cmp("frame_period", frame_start, 1'b1);

        for (int i = 0; i < 11; i++) begin
            pattern_sel = 2'(tbl[i].pat);
            solid_color = tbl[i].sol;
            run_to(0);
            run_to(at(tbl[i].x, tbl[i].y));
            cmp($sformatf("tbl%0d_pix", i), {R_out, G_out, B_out, F_out}, tbl[i].exp);
        end

        // Solid colour changed mid-frame takes effect only at the next frame origin.
        pattern_sel = 2'd3;
        solid_color = 16'hA5C3;
        run_to(0);
        run_to(at(0, 5));
        cmp("solid_before", {R_out, G_out, B_out, F_out}, 16'hA5C3);
        solid_color = 16'h1234;
        run_to(at(3, 20));
        cmp("solid_mid", {R_out, G_out, B_out, F_out}, 16'hA5C3);
        run_to(0);
        cmp("solid_origin", frame_start, 1'b1);
        run_to(at(0, 0));
        cmp("solid_after", {R_out, G_out, B_out, F_out}, 16'h1234);

        // Dropping enable mid-frame drains the rest of the frame.
        pattern_sel = 2'(($urandom % 3));
        run_to(20 * HT);
        enable = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (busy && n < FT + 8);
        cmp("drain_len", n, FT - 20 * HT);
        repeat (5) tick();
        cmp("idle_outputs", {HSYNC_out, VSYNC_out, DE_out, busy, R_out, G_out, B_out, F_out},
            {1'b1, 1'b1, 1'b0, 1'b0, 16'h0});
        enable = 1'b1;
        tick();
        cmp("restart_edge1", {frame_start, busy}, 2'b00);
        tick();
        cmp("restart_edge2", {frame_start, busy, HSYNC_out}, 3'b110);

        // Random pattern/colour churn across a frame boundary, all checked by the model.
        repeat (3) begin
            run_to(at($urandom_range(0, HA - 1), $urandom_range(0, VA - 1)));
            pattern_sel = 2'($urandom);
            solid_color = 16'($urandom);
        end

        // Mid-frame reset drops everything at once; restart timing matches startup.
        run_to(10 * HT + 20);
        reset_n = 1'b0;
        pattern_sel = 2'd1;
        tick();
        cmp("reset_mid", {HSYNC_out, VSYNC_out, DE_out, frame_start, busy, R_out, G_out, B_out, F_out},
            {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0});
        reset_n = 1'b1;
        tick();
        cmp("rerun_edge1", {frame_start, busy}, 2'b00);
        tick();
        cmp("rerun_edge2", {frame_start, busy, HSYNC_out, VSYNC_out}, 4'b1100);

        // Checker transition on line 0 moves left one pixel per frame when scrolling.
        for (int f = 0; f < 3; f++) begin
            run_to(at(0, 0));
            prev = {R_out, G_out, B_out, F_out};
            trans = -1;
            for (int x = 1; x < 16; x++) begin
                tick();
                cur = {R_out, G_out, B_out, F_out};
                if (cur != prev && trans < 0) trans = x;
                prev = cur;
            end
            cmp($sformatf("checker_edge_f%0d", f), trans, SCROLL ? (8 - f) % 16 : 8);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
